// File: rtl/subcounter_pkg.sv
// ============================================================================
// Module : subcounter_pkg
// Desc   : Shared encodings for the subcounter driver (sub-commands, host ops,
//          driver FSM states) and the op-to-command mapping.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package subcounter_pkg;

  localparam logic [1:0] CMD_RESET = 2'b00;
  localparam logic [1:0] CMD_INC   = 2'b01;
  localparam logic [1:0] CMD_HOLD  = 2'b10;
  localparam logic [1:0] CMD_DEC   = 2'b11;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_SUB    = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  function automatic logic [1:0] op_to_cmd(input logic [1:0] op);
    logic [1:0] cmd;
    case (op)
      OP_CLEAR: cmd = CMD_RESET;
      OP_ADD:   cmd = CMD_INC;
      OP_SUB:   cmd = CMD_DEC;
      default:  cmd = CMD_HOLD;
    endcase
    return cmd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/subcounter_driver_if.sv
// ============================================================================
// Module : subcounter_driver_if
// Desc   : Host request/response channels of the subcounter driver.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface subcounter_driver_if #(
  parameter int GRANULARITY = 4,
  parameter int AMT_W       = 8
);

  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [AMT_W-1:0]       req_amount;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [GRANULARITY-1:0] rsp_data;
  logic                   rsp_wrap;

  // Host side
  modport master (
    output req_valid, req_op, req_amount, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_wrap
  );

  // Driver side
  modport slave (
    input  req_valid, req_op, req_amount, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_wrap
  );

endinterface

`default_nettype wire

// File: rtl/subcounter_driver.sv
// ============================================================================
// Module : subcounter_driver
// Desc   : Expands host CLEAR/ADD/SUB/READ ops into subcounter sub-commands
//          and returns the resulting value plus a wrap flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subcounter_driver
  import subcounter_pkg::*;
#(
  parameter int GRANULARITY = 4,
  parameter int AMT_W       = 8
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  subcounter_driver_if.slave          bus,
  output logic [1:0]                  sub_command_out,
  input  wire logic [GRANULARITY-1:0] data_in
);

  state_e                 state_q;
  logic [1:0]             sub_cmd_q;
  logic [AMT_W-1:0]       count_q;
  logic [AMT_W-1:0]       count_d;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic [GRANULARITY-1:0] rsp_data_q;
  logic                   rsp_wrap_q;
  logic                   rsp_wrap_d;

  // data_in still shows the pre-command value, so a wrap is seen as the
  // command about to cross the boundary.
  always_comb begin
    count_d    = count_q - AMT_W'(1);
    rsp_wrap_d = rsp_wrap_q;
    if ((sub_cmd_q == CMD_INC && data_in == {GRANULARITY{1'b1}}) ||
        (sub_cmd_q == CMD_DEC && data_in == {GRANULARITY{1'b0}})) begin
      rsp_wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sub_cmd_q   <= CMD_HOLD;
      count_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_wrap_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_ready_q && bus.req_valid) begin
            req_ready_q <= 1'b0;
            rsp_wrap_q  <= 1'b0;
            if (bus.req_op == OP_CLEAR) begin
              count_q   <= AMT_W'(1);
              sub_cmd_q <= CMD_RESET;
              state_q   <= ST_ISSUE;
            end else if ((bus.req_op == OP_ADD || bus.req_op == OP_SUB) &&
                         bus.req_amount != '0) begin
              count_q   <= bus.req_amount;
              sub_cmd_q <= op_to_cmd(bus.req_op);
              state_q   <= ST_ISSUE;
            end else begin
              state_q   <= ST_SETTLE;
            end
          end
        end
        ST_ISSUE: begin
          rsp_wrap_q <= rsp_wrap_d;
          count_q    <= count_d;
          if (count_q == AMT_W'(1)) begin
            sub_cmd_q <= CMD_HOLD;
            state_q   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          rsp_data_q  <= data_in;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          sub_cmd_q <= CMD_HOLD;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign sub_command_out = sub_cmd_q;
  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_wrap    = rsp_wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_subcounter_driver.sv
// ============================================================================
// Module : tb_subcounter_driver
// Desc   : Bench for subcounter_driver with a 4-bit subcounter as the load.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subcounter_driver;
  import subcounter_pkg::*;

  localparam int GW = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    sub_command_out;
  logic [GW-1:0] sc = '0;

  subcounter_driver_if #(.GRANULARITY(GW), .AMT_W(AW)) bus();

  subcounter_driver #(.GRANULARITY(GW), .AMT_W(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .sub_command_out (sub_command_out),
    .data_in         (sc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Subcounter load: no reset of its own, keeps value across driver resets.
  always @(posedge clk) begin
    case (sub_command_out)
      CMD_RESET: sc <= '0;
      CMD_INC:   sc <= sc + 1'b1;
      CMD_DEC:   sc <= sc - 1'b1;
      default:   sc <= sc;
    endcase
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_up();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Behavioural model: counter value, expected per-cycle commands, response window
  int         m_val       = 0;
  int         m_prev_val  = 0;
  bit         m_in_op     = 1'b0;
  int         m_rsp_from  = 0;
  int         m_exp_data  = 0;
  bit         m_exp_wrap  = 1'b0;
  int         rdy_ok_from = 3;
  bit         chk_en      = 1'b0;
  logic [1:0] exp_cmd [int];

  always @(negedge clk) begin
    logic [1:0] ec;
    if (chk_en) begin
      ec = exp_cmd.exists(cyc) ? exp_cmd[cyc] : CMD_HOLD;
      chk("sub_command_out", 32'(sub_command_out), 32'(ec));
      chk("req_ready", 32'(bus.req_ready), 32'(!m_in_op && cyc >= rdy_ok_from));
      if (m_in_op && cyc >= m_rsp_from) begin
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_data", 32'(bus.rsp_data), 32'(m_exp_data));
        chk("rsp_wrap", 32'(bus.rsp_wrap), 32'(m_exp_wrap));
      end else begin
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end
    end
  end

  task automatic accept(input logic [1:0] op, input int n, output int e);
    int         t;
    int         k;
    logic       rr;
    logic [1:0] cmd;
    bus.req_op     = op;
    bus.req_amount = AW'(n);
    bus.req_valid  = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      rr = bus.req_ready;
      @(posedge clk);
      #1;
      if (rr === 1'b1) break;
      t++;
      if (t > 400) begin
        checks++; failures++;
        $display("FAIL req_timeout: req_ready never high (cycle %0d)", cyc);
        finish_up();
      end
    end
    e = cyc;
    bus.req_valid = 1'b0;
    m_prev_val = m_val;
    case (op)
      OP_CLEAR: begin k = 1; cmd = CMD_RESET; m_exp_data = 0; m_exp_wrap = 1'b0; end
      OP_ADD: begin
        k = n; cmd = CMD_INC;
        m_exp_data = (m_val + n) % 16;
        m_exp_wrap = (m_val + n) > 15;
      end
      OP_SUB: begin
        k = n; cmd = CMD_DEC;
        m_exp_data = ((m_val - n) % 16 + 16) % 16;
        m_exp_wrap = n > m_val;
      end
      default: begin k = 0; cmd = CMD_HOLD; m_exp_data = m_val; m_exp_wrap = 1'b0; end
    endcase
    for (int i = 0; i < k; i++) exp_cmd[e + i] = cmd;
    m_val      = m_exp_data;
    m_rsp_from = e + k + 1;
    m_in_op    = 1'b1;
  endtask

  task automatic collect(input int hold, output logic [GW-1:0] d, output logic w,
                         output int first, output int h);
    int t;
    bus.rsp_ready = 1'b0;
    t = 0;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1) begin
      t++;
      if (t > 400) begin
        checks++; failures++;
        $display("FAIL rsp_timeout: rsp_valid never high (cycle %0d)", cyc);
        finish_up();
      end
      @(negedge clk);
    end
    first = cyc;
    repeat (hold) @(negedge clk);
    d = bus.rsp_data;
    w = bus.rsp_wrap;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    h = cyc;
    m_in_op = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input int n, input int hold,
                       output logic [GW-1:0] d, output logic w, output int lat);
    int e, first, h;
    accept(op, n, e);
    collect(hold, d, w, first, h);
    lat = first - e + 1;
  endtask

  initial begin
    logic [GW-1:0] d;
    logic          w;
    int            lat, e, e2, first, h, op, n, r;

    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_amount = '0;
    bus.rsp_ready  = 1'b0;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("reset_rsp_wrap", 32'(bus.rsp_wrap), 32'd0);
    rst = 1'b0;

    do_op(OP_CLEAR, 0, 0, d, w, lat);
    chk("clear_data", 32'(d), 32'h0);
    chk("clear_wrap", 32'(w), 32'd0);

    do_op(OP_ADD, 5, 0, d, w, lat);
    chk("add5_data", 32'(d), 32'h5);
    chk("add5_wrap", 32'(w), 32'd0);
    chk("add5_latency", 32'(lat), 32'd7);
    do_op(OP_READ, 0, 0, d, w, lat);
    chk("read5_data", 32'(d), 32'h5);
    chk("read_latency", 32'(lat), 32'd2);

    do_op(OP_CLEAR, 0, 0, d, w, lat);
    do_op(OP_ADD, 20, 0, d, w, lat);
    chk("add20_data", 32'(d), 32'h4);
    chk("add20_wrap", 32'(w), 32'd1);
    do_op(OP_ADD, 0, 0, d, w, lat);
    chk("add0_data", 32'(d), 32'h4);
    chk("add0_wrap", 32'(w), 32'd0);

    do_op(OP_CLEAR, 0, 0, d, w, lat);
    do_op(OP_SUB, 1, 0, d, w, lat);
    chk("sub1_data", 32'(d), 32'hF);
    chk("sub1_wrap", 32'(w), 32'd1);
    do_op(OP_SUB, 15, 0, d, w, lat);
    chk("sub15_data", 32'(d), 32'h0);
    chk("sub15_wrap", 32'(w), 32'd0);

    // Backpressure with a second request already pending
    accept(OP_ADD, 3, e);
    bus.req_op     = OP_READ;
    bus.req_amount = '0;
    bus.req_valid  = 1'b1;
    collect(3, d, w, first, h);
    chk("bp_data", 32'(d), 32'h3);
    accept(OP_READ, 0, e2);
    chk("bp_second_accept", 32'(e2), 32'(h + 1));
    collect(0, d, w, first, h);
    chk("bp_read_data", 32'(d), 32'h3);

    // Reset in the middle of ADD 10 after three INC cycles
    do_op(OP_CLEAR, 0, 0, d, w, lat);
    accept(OP_ADD, 10, e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    m_in_op = 1'b0;
    for (int i = 3; i < 10; i++) exp_cmd.delete(e + i);
    m_val = (m_prev_val + 3) % 16;
    rdy_ok_from = cyc + 1;
    rst = 1'b0;
    chk("abort_sc_value", 32'(sc), 32'h3);
    do_op(OP_READ, 0, 0, d, w, lat);
    chk("abort_read_data", 32'(d), 32'h3);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      r  = $urandom_range(0, 9);
      if (r == 0)      n = 0;
      else if (r == 1) n = $urandom_range(16, 255);
      else             n = $urandom_range(1, 20);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      do_op(2'(op), n, $urandom_range(0, 3), d, w, lat);
    end

    repeat (3) @(posedge clk);
    #1;
    finish_up();
  end

endmodule

`default_nettype wire

// File: doc/subcounter_driver.md
Name: subcounter_driver

Overview:
Command-side initiator for one subcounter. Accepts host operations (CLEAR, ADD n, SUB n, READ) on a valid/ready request channel and expands each into a cycle-by-cycle stream of 2-bit sub-commands for the subcounter. It then samples the subcounter's data output back and returns the value and a wrap flag on a valid/ready response channel. It sits between the shared-counter control logic and each subcounter instance.

Parameters:
granularity, 4, width of subcounter data (must match the attached subcounter)
AMT_W, 8, width of req_amount; max repeat count 2^AMT_W-1

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
req_valid  input  1  host request valid
req_ready  output  1  driver can accept request
req_op  input  2  00 CLEAR, 01 ADD, 10 SUB, 11 READ
req_amount  input  AMT_W  repeat count for ADD/SUB; ignored otherwise
rsp_valid  output  1  response valid
rsp_ready  input  1  host accepts response
rsp_data  output  granularity  subcounter value after operation
rsp_wrap  output  1  counter wrapped during operation
sub_command_out  output  2  to subcounter sub_command_in: 00 reset, 01 increment, 10 hold, 11 decrement
data_in  input  granularity  from subcounter data_out

Behaviour:
- Subcounter contract: command sampled at posedge, data_out updates at that same edge and is visible next cycle.
- Reset (rst=1 at posedge): state IDLE, sub_command_out=10 (hold), req_ready=0 in the reset cycle then 1, rsp_valid=0, rsp_data=0, rsp_wrap=0, remaining count=0.
- Reset mid-operation: abort immediately; sub_command_out=10 from the next cycle, no response issued. Subcounter keeps its partial value; host issues CLEAR to recover.
- States: IDLE, ISSUE, SETTLE, RESP.
- IDLE: req_ready=1, sub_command_out=10. Handshake at posedge when req_valid&&req_ready: latch op/amount, clear wrap, req_ready drops.
  - CLEAR: go ISSUE with count 1, command 00.
  - ADD/SUB with amount>0: go ISSUE with count=amount, command 01/11.
  - ADD/SUB with amount=0, or READ: go SETTLE directly; no non-hold command is emitted.
- ISSUE: sub_command_out is the latched command for exactly `count` consecutive cycles, starting the cycle after acceptance. Decrement count each cycle; on last cycle go SETTLE.
- Wrap detect in ISSUE: INC while data_in=all ones, or DEC while data_in=0, sets rsp_wrap sticky. CLEAR never sets wrap.
- SETTLE: one cycle with sub_command_out=10; capture data_in into rsp_data at end of cycle; go RESP.
- RESP: rsp_valid=1; rsp_data/rsp_wrap held stable until rsp_ready=1 at posedge. Then rsp_valid=0 and return to IDLE.
- Latency: ADD n (n≥1) accepted at edge E gives rsp_valid high from edge E+n+2. READ gives rsp_valid at E+2.
- Wrap-around: arithmetic is mod 2^granularity; multiple wraps in one op still give rsp_wrap=1 (not a count).
- req_ready=0 in every non-IDLE state; no request queuing.
- All outputs registered; sub_command_out never X and never 00 except during CLEAR issue.

Decomposition:
- Shared package subcounter_pkg:
  - sub-command constants: CMD_RESET=00, CMD_INC=01, CMD_HOLD=10, CMD_DEC=11
  - host op constants: OP_CLEAR, OP_ADD, OP_SUB, OP_READ
  - FSM state encoding
- Single module; no sub-module is natural. Remaining-count register and wrap logic are too small to split.

Test Plan:
Bench instantiates subcounter (granularity=4) on the driver outputs as the load.
1. rst 2 cycles, then CLEAR -> sub_command_out=00 for exactly 1 cycle, rsp_data=0000, rsp_wrap=0.
2. After CLEAR, ADD 5 -> exactly 5 consecutive cycles of 01, rsp_valid at acceptance+7, rsp_data=0101, rsp_wrap=0. READ -> 0101 at acceptance+2.
3. From 0, ADD 20 -> rsp_data=0100, rsp_wrap=1. Then ADD 0 -> no 01 cycles, rsp_data=0100, rsp_wrap=0.
4. From 0, SUB 1 -> one 11 cycle, rsp_data=1111, rsp_wrap=1. Then SUB 15 -> 0000, rsp_wrap=0.
5. Backpressure: hold rsp_ready=0 for 3 cycles with a second req_valid pending -> rsp_data stable, req_ready=0 throughout. Second request accepted only in the cycle after rsp handshake.
6. ADD 10 from 0, assert rst after 3 INC cycles -> sub_command_out=10 next cycle, no rsp_valid, subcounter holds 0011. Subsequent READ -> 0011.
